// File: rtl/ps2_device_pkg.sv
// Shared PS/2 definitions: frame length, device FSM states and the odd-parity helper.
package ps2_device_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned BIT_W          = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_HI,
    S_TX_LO,
    S_RX_LO,
    S_RX_HI,
    S_ACK_HI,
    S_ACK_LO,
    S_INHIBIT
  } state_t;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines; both reset to the idle-high level.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic cs,
  output logic ds
);

  logic [1:0] c_q;
  logic [1:0] d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= 2'b11;
      d_q <= 2'b11;
    end else begin
      c_q <= {c_q[0], ps2c};
      d_q <= {d_q[0], ps2d};
    end
  end

  assign cs = c_q[1];
  assign ds = d_q[1];

endmodule

// File: rtl/ps2_device.sv
// Device-side PS/2 port: generates the PS/2 clock, sends bytes to the host and
// receives host commands after a request-to-send. Lines are only pulled low or released.
module ps2_device
  import ps2_device_pkg::*;
#(
  parameter int unsigned CLK_HALF   = 2000,
  parameter int unsigned SAMPLE_DLY = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       ready,
  output logic       tx_done_tick,
  output logic       tx_abort_tick,
  output logic       rx_done_tick,
  output logic       rx_err,
  output logic [7:0] dout
);

  localparam int unsigned     TW       = $clog2(CLK_HALF);
  localparam logic [TW-1:0]   T_LOAD   = TW'(CLK_HALF - 1);
  localparam logic [TW-1:0]   T_SAMPLE = TW'(CLK_HALF - 1 - SAMPLE_DLY);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PS2_FRAME_BITS - 1);

  logic cs;
  logic ds;

  state_t                    state, state_nx;
  logic [TW-1:0]             timer, timer_nx;
  logic [BIT_W-1:0]          bit_cnt, bit_nx;
  logic [PS2_FRAME_BITS-1:0] sh, sh_nx;
  logic                      drv_c, drv_c_nx;
  logic                      drv_d, drv_d_nx;
  logic                      ready_nx;
  logic                      tx_done_nx, tx_abort_nx, rx_done_nx, rx_err_nx;
  logic [7:0]                dout_nx;
  logic                      timer_end;

  ps2_line_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .ps2c  (ps2c),
    .ps2d  (ps2d),
    .cs    (cs),
    .ds    (ds)
  );

  assign ps2c = drv_c ? 1'b0 : 1'bz;
  assign ps2d = drv_d ? 1'b0 : 1'bz;

  assign timer_end = (timer == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      sh            <= '0;
      drv_c         <= 1'b0;
      drv_d         <= 1'b0;
      ready         <= 1'b0;
      tx_done_tick  <= 1'b0;
      tx_abort_tick <= 1'b0;
      rx_done_tick  <= 1'b0;
      rx_err        <= 1'b0;
      dout          <= '0;
    end else begin
      state         <= state_nx;
      timer         <= timer_nx;
      bit_cnt       <= bit_nx;
      sh            <= sh_nx;
      drv_c         <= drv_c_nx;
      drv_d         <= drv_d_nx;
      ready         <= ready_nx;
      tx_done_tick  <= tx_done_nx;
      tx_abort_tick <= tx_abort_nx;
      rx_done_tick  <= rx_done_nx;
      rx_err        <= rx_err_nx;
      dout          <= dout_nx;
    end
  end

  // Next state and registered outputs; every phase transition happens at timer_end,
  // so the timer reloads by default there and counts down otherwise.
  always_comb begin
    state_nx    = state;
    timer_nx    = timer_end ? T_LOAD : timer - TW'(1);
    bit_nx      = bit_cnt;
    sh_nx       = sh;
    drv_c_nx    = drv_c;
    drv_d_nx    = drv_d;
    tx_done_nx  = 1'b0;
    tx_abort_nx = 1'b0;
    rx_done_nx  = 1'b0;
    rx_err_nx   = rx_err;
    dout_nx     = dout;

    case (state)
      S_IDLE: begin
        drv_c_nx = 1'b0;
        drv_d_nx = 1'b0;
        // Host RTS has priority over a local write in the same cycle.
        if (cs && !ds) begin
          state_nx = S_RX_LO;
          drv_c_nx = 1'b1;
          timer_nx = T_LOAD;
          bit_nx   = '0;
        end else if (wr && ready && cs && ds) begin
          sh_nx    = {1'b1, odd_parity(din), din, 1'b0};
          state_nx = S_TX_HI;
          drv_d_nx = 1'b1;
          timer_nx = T_LOAD;
          bit_nx   = '0;
        end
      end

      S_TX_HI: begin
        if (timer_end) begin
          if (!cs && (bit_cnt < LAST_BIT)) begin
            tx_abort_nx = 1'b1;
            drv_c_nx    = 1'b0;
            drv_d_nx    = 1'b0;
            state_nx    = S_INHIBIT;
          end else begin
            drv_c_nx = 1'b1;
            state_nx = S_TX_LO;
          end
        end
      end

      S_TX_LO: begin
        if (timer_end) begin
          drv_c_nx = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            drv_d_nx   = 1'b0;
            tx_done_nx = 1'b1;
            state_nx   = S_IDLE;
          end else begin
            sh_nx    = {1'b1, sh[PS2_FRAME_BITS-1:1]};
            drv_d_nx = ~sh[1];
            bit_nx   = bit_cnt + BIT_W'(1);
            state_nx = S_TX_HI;
          end
        end
      end

      S_RX_LO: begin
        if (timer_end) begin
          drv_c_nx = 1'b0;
          bit_nx   = bit_cnt + BIT_W'(1);
          state_nx = S_RX_HI;
        end
      end

      S_RX_HI: begin
        if (timer == T_SAMPLE) begin
          if (!cs) begin
            rx_err_nx = 1'b1;
            timer_nx  = T_LOAD;
            state_nx  = S_INHIBIT;
          end else if (bit_cnt == LAST_BIT) begin
            if (ds) begin
              drv_d_nx = 1'b1;
              state_nx = S_ACK_HI;
            end else begin
              rx_err_nx  = 1'b1;
              rx_done_nx = 1'b1;
              timer_nx   = T_LOAD;
              state_nx   = S_INHIBIT;
            end
          end else begin
            sh_nx = {ds, sh[PS2_FRAME_BITS-1:1]};
          end
        end else if (timer_end) begin
          drv_c_nx = 1'b1;
          state_nx = S_RX_LO;
        end
      end

      S_ACK_HI: begin
        if (timer_end) begin
          drv_c_nx = 1'b1;
          state_nx = S_ACK_LO;
        end
      end

      S_ACK_LO: begin
        // Nine shifts leave data in sh[9:2] and parity in sh[10].
        if (timer_end) begin
          drv_c_nx   = 1'b0;
          drv_d_nx   = 1'b0;
          rx_done_nx = 1'b1;
          dout_nx    = sh[9:2];
          rx_err_nx  = ~(^sh[10:2]);
          state_nx   = S_IDLE;
        end
      end

      S_INHIBIT: begin
        drv_c_nx = 1'b0;
        drv_d_nx = 1'b0;
        if (!(cs && ds)) begin
          timer_nx = T_LOAD;
        end else if (timer_end) begin
          state_nx = S_IDLE;
        end
      end
    endcase

    ready_nx = (state_nx == S_IDLE);
  end

endmodule
